// File: rtl/gemm_desc_queue_pkg.sv
// GEMM descriptor queue: shared descriptor type,
// register offsets and status bit positions.
package gemm_cfg_pkg;

  localparam int DIM_W = 5;

  typedef struct packed {
    logic [31:0]      a_addr;
    logic [31:0]      b_addr;
    logic [31:0]      c_addr;
    logic [31:0]      a_stride;
    logic [31:0]      b_stride;
    logic [DIM_W-1:0] nsize;
    logic [DIM_W-1:0] ksize;
    logic [DIM_W-1:0] msize;
    logic             store;
    logic             overwrite;
  } desc_t;

  localparam logic [5:0] OFF_A      = 6'h00;
  localparam logic [5:0] OFF_B      = 6'h04;
  localparam logic [5:0] OFF_C      = 6'h08;
  localparam logic [5:0] OFF_SA     = 6'h0C;
  localparam logic [5:0] OFF_SB     = 6'h10;
  localparam logic [5:0] OFF_CTRL   = 6'h14;
  localparam logic [5:0] OFF_DIMS   = 6'h18;
  localparam logic [5:0] OFF_DOORB  = 6'h1C;
  localparam logic [5:0] OFF_STATUS = 6'h20;
  localparam logic [5:0] OFF_DONE   = 6'h24;
  localparam logic [5:0] OFF_IRQEN  = 6'h28;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_PEND  = 3;
  localparam int ST_CNT   = 8;

endpackage

// File: rtl/gemm_desc_queue_if.sv
// System bus port of the GEMM descriptor queue:
// single-cycle strobe, combinational read data.
interface gemm_desc_queue_if;
  logic        en;
  logic        rdwr;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output en, rdwr, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  en, rdwr, addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/gemm_desc_queue_desc_fifo.sv
// DEPTH x desc_t synchronous FIFO with a
// registered head so consumer outputs never glitch.
module desc_fifo
  import gemm_cfg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  desc_t         data_i,
  input  logic          pop_i,
  output desc_t         head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  desc_t          mem_q [DEPTH];
  desc_t          mem_d [DEPTH];
  desc_t          head_q, head_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           do_pop, do_push;

  // A full queue still accepts a push when a pop frees the slot.
  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != FULLC) | do_pop);

  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (cnt_d != '0) head_d = mem_d[rd_d];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      head_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = head_q;
  assign full_o  = (cnt_q == FULLC);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/gemm_desc_queue.sv
// Memory-mapped GEMM tile descriptor queue with
// doorbell push, status, done counter and irq.
module gemm_desc_queue
  import gemm_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int          DEPTH     = 4,
  parameter int          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  gemm_desc_queue_if.slave   bus,
  output logic               desc_valid,
  input  logic               desc_ready,
  output logic [31:0]        tile_A_addr,
  output logic [31:0]        tile_B_addr,
  output logic [31:0]        tile_C_addr,
  output logic [31:0]        tile_A_stride,
  output logic [31:0]        tile_B_stride,
  output logic [DIM_W-1:0]   msize,
  output logic [DIM_W-1:0]   ksize,
  output logic [DIM_W-1:0]   nsize,
  output logic               store,
  output logic               overwrite,
  input  logic               tile_done,
  output logic               irq
);

  localparam int CW = $clog2(DEPTH + 1);

  desc_t            stg_q, stg_d, head;
  logic             ovf_q, ovf_d;
  logic             pend_q, pend_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             hit, wr, rd, push, w1c;
  logic             full, empty;
  logic [CW-1:0]    count;
  logic [5:0]       off;
  logic [31:0]      wd, rdata;

  assign hit  = (bus.addr[31:6] == BASE_ADDR[31:6]);
  assign off  = bus.addr[5:0];
  assign wd   = bus.wr_data;
  assign wr   = bus.en & bus.rdwr & hit;
  assign rd   = bus.en & ~bus.rdwr & hit;
  assign push = wr & (off == OFF_DOORB);
  assign w1c  = wr & (off == OFF_STATUS);

  always_comb begin
    stg_d = stg_q;
    if (wr) begin
      case (off)
        OFF_A:  stg_d.a_addr   = wd;
        OFF_B:  stg_d.b_addr   = wd;
        OFF_C:  stg_d.c_addr   = wd;
        OFF_SA: stg_d.a_stride = wd;
        OFF_SB: stg_d.b_stride = wd;
        OFF_CTRL: begin
          stg_d.store     = wd[0];
          stg_d.overwrite = wd[1];
        end
        OFF_DIMS: begin
          stg_d.msize = wd[DIM_W-1:0];
          stg_d.ksize = wd[2*DIM_W-1:DIM_W];
          stg_d.nsize = wd[3*DIM_W-1:2*DIM_W];
        end
        default: ;
      endcase
    end
  end

  // Set events are applied after W1C so they win a same-cycle clear.
  always_comb begin
    ovf_d    = ovf_q;
    pend_d   = pend_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    if (w1c && wd[ST_OVF])  ovf_d  = 1'b0;
    if (w1c && wd[ST_PEND]) pend_d = 1'b0;
    if (push && full && !desc_ready) ovf_d = 1'b1;
    if (tile_done) begin
      pend_d = 1'b1;
      done_d = done_q + CNT_W'(1);
    end
    if (wr && off == OFF_IRQEN) irq_en_d = wd[0];
    irq_d = pend_q & irq_en_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stg_q    <= '0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      done_q   <= '0;
    end else begin
      stg_q    <= stg_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      done_q   <= done_d;
    end
  end

  desc_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .data_i  (stg_q),
    .pop_i   (desc_ready),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (off)
        OFF_A:    rdata = stg_q.a_addr;
        OFF_B:    rdata = stg_q.b_addr;
        OFF_C:    rdata = stg_q.c_addr;
        OFF_SA:   rdata = stg_q.a_stride;
        OFF_SB:   rdata = stg_q.b_stride;
        OFF_CTRL: rdata[1:0] = {stg_q.overwrite, stg_q.store};
        OFF_DIMS:
          rdata[3*DIM_W-1:0] = {stg_q.nsize, stg_q.ksize, stg_q.msize};
        OFF_STATUS: begin
          rdata[ST_EMPTY]       = empty;
          rdata[ST_FULL]        = full;
          rdata[ST_OVF]         = ovf_q;
          rdata[ST_PEND]        = pend_q;
          rdata[ST_CNT +: CW]   = count;
        end
        OFF_DONE:  rdata[CNT_W-1:0] = done_q;
        OFF_IRQEN: rdata[0] = irq_en_q;
        default: ;
      endcase
    end
  end

  assign bus.rd_data   = rdata;
  assign desc_valid    = ~empty;
  assign tile_A_addr   = head.a_addr;
  assign tile_B_addr   = head.b_addr;
  assign tile_C_addr   = head.c_addr;
  assign tile_A_stride = head.a_stride;
  assign tile_B_stride = head.b_stride;
  assign msize         = head.msize;
  assign ksize         = head.ksize;
  assign nsize         = head.nsize;
  assign store         = head.store;
  assign overwrite     = head.overwrite;
  assign irq           = irq_q;

endmodule

// File: tb/tb_gemm_desc_queue.sv
// Directed scoreboard bench for gemm_desc_queue.
// Expected descriptors queue on push, compare on pop.
module tb_gemm_desc_queue;
  import gemm_cfg_pkg::*;

  localparam logic [31:0] BASE  = 32'h9000_0000;
  localparam int          DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             desc_valid, desc_ready, tile_done, irq;
  logic [31:0]      a_o, b_o, c_o, sa_o, sb_o;
  logic [DIM_W-1:0] m_o, k_o, n_o;
  logic             st_o, ow_o;

  gemm_desc_queue_if bus ();

  gemm_desc_queue #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .tile_A_addr   (a_o),
    .tile_B_addr   (b_o),
    .tile_C_addr   (c_o),
    .tile_A_stride (sa_o),
    .tile_B_stride (sb_o),
    .msize         (m_o),
    .ksize         (k_o),
    .nsize         (n_o),
    .store         (st_o),
    .overwrite     (ow_o),
    .tile_done     (tile_done),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    mcnt  = 0;
  desc_t sb[$];
  desc_t stg;
  desc_t e;

  function automatic logic [31:0] st(
    input logic emp, input logic ful,
    input logic ovf, input logic pnd, input int cnt
  );
    logic [7:0] c8;
    c8 = 8'(cnt);
    return {16'h0, c8, 4'h0, pnd, ovf, ful, emp};
  endfunction

  task automatic chk(
    input string tag, input logic [31:0] obs, input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic head_chk(input string tag, input desc_t x);
    chk({tag, "_a"},  a_o,  x.a_addr);
    chk({tag, "_b"},  b_o,  x.b_addr);
    chk({tag, "_c"},  c_o,  x.c_addr);
    chk({tag, "_sa"}, sa_o, x.a_stride);
    chk({tag, "_sb"}, sb_o, x.b_stride);
    chk({tag, "_dims"},
        {15'd0, n_o, k_o, m_o, ow_o, st_o},
        {15'd0, x.nsize, x.ksize, x.msize, x.overwrite, x.store});
  endtask

  task automatic bus_wr(
    input logic [5:0] off, input logic [31:0] d,
    input logic td = 1'b0
  );
    @(negedge clk);
    bus.en = 1'b1; bus.rdwr = 1'b1;
    bus.addr = {BASE[31:6], off}; bus.wr_data = d;
    tile_done = td;
    @(negedge clk);
    bus.en = 1'b0; bus.rdwr = 1'b0; tile_done = 1'b0;
  endtask

  task automatic rd_chk(
    input string tag, input logic [5:0] off, input logic [31:0] exp
  );
    bus.en = 1'b1; bus.rdwr = 1'b0;
    bus.addr = {BASE[31:6], off};
    #1;
    chk(tag, bus.rd_data, exp);
    bus.en = 1'b0;
  endtask

  task automatic ring(input string tag, input logic rdy);
    logic pop;
    @(negedge clk);
    pop = rdy && (mcnt > 0);
    if (pop) begin
      e = sb.pop_front();
      head_chk(tag, e);
    end
    bus.en = 1'b1; bus.rdwr = 1'b1;
    bus.addr = {BASE[31:6], OFF_DOORB}; bus.wr_data = 32'h1;
    desc_ready = rdy;
    if (mcnt < DEPTH || pop) begin
      sb.push_back(stg);
      if (!pop) mcnt++;
    end
    @(negedge clk);
    bus.en = 1'b0; bus.rdwr = 1'b0; desc_ready = 1'b0;
  endtask

  task automatic pop1(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, desc_valid}, 32'd1);
    e = sb.pop_front();
    head_chk(tag, e);
    desc_ready = 1'b1;
    mcnt--;
    @(negedge clk);
    desc_ready = 1'b0;
  endtask

  task automatic set_a(input logic [31:0] a);
    bus_wr(OFF_A, a);
    stg.a_addr = a;
  endtask

  initial begin
    bus.en = 1'b0; bus.rdwr = 1'b0;
    bus.addr = '0; bus.wr_data = '0;
    desc_ready = 1'b0; tile_done = 1'b0;
    stg = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    rd_chk("rst_status", OFF_STATUS, 32'h1);
    chk("rst_valid", {31'd0, desc_valid}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_head_a", a_o, 32'd0);
    rd_chk("rst_done", OFF_DONE, 32'd0);

    bus_wr(OFF_A, 32'h1000);
    bus_wr(OFF_B, 32'h2000);
    bus_wr(OFF_C, 32'h3000);
    bus_wr(OFF_SA, 32'd64);
    bus_wr(OFF_SB, 32'd128);
    bus_wr(OFF_CTRL, 32'h3);
    bus_wr(OFF_DIMS, 32'h4104);
    stg.a_addr = 32'h1000; stg.b_addr = 32'h2000;
    stg.c_addr = 32'h3000;
    stg.a_stride = 32'd64; stg.b_stride = 32'd128;
    stg.store = 1'b1; stg.overwrite = 1'b1;
    stg.msize = 5'd4; stg.ksize = 5'd8; stg.nsize = 5'd16;
    rd_chk("rb_a", OFF_A, 32'h1000);
    rd_chk("rb_ctrl", OFF_CTRL, 32'h3);
    rd_chk("rb_dims", OFF_DIMS, 32'h4104);
    rd_chk("rd_doorbell", OFF_DOORB, 32'h0);
    rd_chk("rd_unmapped", 6'h2C, 32'h0);

    ring("push1", 1'b0);
    chk("push1_valid", {31'd0, desc_valid}, 32'd1);
    head_chk("push1_head", sb[0]);
    rd_chk("push1_status", OFF_STATUS, st(0, 0, 0, 0, 1));

    for (int i = 0; i < DEPTH + 1; i++) begin
      set_a(32'h1100 + 32'(i) * 32'h100);
      ring("fill", 1'b0);
    end
    rd_chk("ovf_status", OFF_STATUS, st(0, 1, 1, 0, DEPTH));
    bus_wr(OFF_STATUS, 32'h4);
    rd_chk("ovf_clr", OFF_STATUS, st(0, 1, 0, 0, DEPTH));
    rd_chk("stg_kept", OFF_A, 32'h1500);

    set_a(32'hBEEF_0000);
    ring("fullpp", 1'b1);
    rd_chk("fullpp_status", OFF_STATUS, st(0, 1, 0, 0, DEPTH));
    for (int i = 0; i < DEPTH; i++) pop1("drain");
    rd_chk("drained", OFF_STATUS, st(1, 0, 0, 0, 0));
    chk("drained_valid", {31'd0, desc_valid}, 32'd0);
    chk("hold_head", a_o, 32'hBEEF_0000);
    ring("ign_rdy", 1'b1);
    pop1("ign_rdy_pop");

    bus_wr(OFF_IRQEN, 32'h1);
    rd_chk("irqen", OFF_IRQEN, 32'h1);
    repeat (3) begin
      @(negedge clk); tile_done = 1'b1;
      @(negedge clk); tile_done = 1'b0;
    end
    rd_chk("done3", OFF_DONE, 32'd3);
    rd_chk("pend_status", OFF_STATUS, st(1, 0, 0, 1, 0));
    @(negedge clk);
    chk("irq_set", {31'd0, irq}, 32'd1);
    bus_wr(OFF_STATUS, 32'h8);
    rd_chk("pend_clr", OFF_STATUS, st(1, 0, 0, 0, 0));
    @(negedge clk);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    bus_wr(OFF_STATUS, 32'h8, 1'b1);
    rd_chk("set_wins", OFF_STATUS, st(1, 0, 0, 1, 0));
    rd_chk("done4", OFF_DONE, 32'd4);

    for (int i = 0; i < 2; i++) begin
      set_a(32'h5000 + 32'(i));
      ring("wrap_fill", 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      set_a(32'h6000 + 32'(i));
      ring("wrap_pp", 1'b1);
      rd_chk("wrap_cnt", OFF_STATUS, st(0, 0, 0, 1, 2));
    end
    while (mcnt > 0) pop1("wrap_drain");

    ring("pre_rst", 1'b0);
    ring("pre_rst", 1'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    sb.delete(); mcnt = 0; stg = '0;
    chk("mrst_valid", {31'd0, desc_valid}, 32'd0);
    rd_chk("mrst_status", OFF_STATUS, st(1, 0, 0, 0, 0));
    chk("mrst_head", a_o, 32'd0);
    chk("mrst_irq", {31'd0, irq}, 32'd0);
    rd_chk("mrst_done", OFF_DONE, 32'd0);
    rd_chk("mrst_stg", OFF_A, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gemm_desc_queue.md
Name: gemm_desc_queue

Overview:
- Memory-mapped GEMM configuration front-end on the system bus; successor to the per-field config buffers.
- Software fills staging registers, then writes a doorbell that pushes the whole tile descriptor atomically into a DEPTH-entry queue.
- The GEMM controller pops descriptors with a valid/ready handshake.
- Adds readable status/occupancy, sticky overflow, tile-completion counting and an interrupt.

Parameters:
- BASE_ADDR, 32'h9000_0000, base of the 64-byte register window.
- DEPTH, 4, descriptor queue entries (power of 2, >=2).
- DIM_W, 5, width of each of msize/ksize/nsize; 3*DIM_W <= 32.
- CNT_W, 16, width of the completed-tile counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- system_bus_en  in  1  bus access strobe.
- system_bus_rdwr  in  1  1=write, 0=read.
- system_bus_addr  in  32  byte address.
- system_bus_wr_data  in  32  write data.
- system_bus_rd_data  out  32  read data, combinational.
- desc_valid  out  1  queue non-empty.
- desc_ready  in  1  consumer pops the head when desc_valid & desc_ready.
- tile_A_addr, tile_B_addr, tile_C_addr, tile_A_stride, tile_B_stride  out  32 each  head-descriptor fields.
- msize, ksize, nsize  out  DIM_W each  head dimensions.
- store, overwrite  out  1 each  head control bits.
- tile_done  in  1  one-cycle pulse per finished tile.
- irq  out  1  interrupt, level.

Behaviour:
- Register map (offset: access):
  - 0x00 A addr RW; 0x04 B addr RW; 0x08 C addr RW; 0x0C A stride RW; 0x10 B stride RW.
  - 0x14 control RW: [0] store, [1] overwrite.
  - 0x18 dims RW: msize[DIM_W-1:0], ksize next DIM_W bits, nsize next DIM_W bits.
  - 0x1C doorbell WO: any write pushes; reads 0.
  - 0x20 status: [0] empty, [1] full, [2] overflow (sticky, W1C), [3] done_pending (W1C), [15:8] count, other bits 0.
  - 0x24 done_cnt RO: zero-extended.
  - 0x28 irq_en RW: [0].
  - Unmapped offsets: reads return 0, writes ignored.
- Staging registers read back their last written value; unused bits read 0.
- Writes take effect at the clock edge where system_bus_en & system_bus_rdwr are high. Reads are combinational in the same cycle, with no side effects.
- Push: doorbell write while not full stores the staging snapshot at the tail; count+1; staging registers are unchanged.
- Push while full with no pop in that cycle: descriptor dropped, overflow set, count unchanged.
- Push and pop in the same cycle: both take effect and count is unchanged. This holds even when full, because the pop frees the slot.
- Pop: desc_valid & desc_ready; head advances next edge; desc_ready while empty is ignored.
- Head outputs are the head slot contents, registered and glitch-free. They are valid only while desc_valid=1 and hold the last head after draining.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH+1) bits wide.
- tile_done: done_cnt+1 (wraps at 2^CNT_W) and done_pending set.
- A W1C clear and a set event in the same cycle: the set wins.
- irq = done_pending & irq_en, registered; asserts 1 cycle after the setting edge.
- Reset: all staging registers, queue slots, pointers, count, overflow, done_pending, done_cnt and irq_en go to 0.
  - Outputs after reset: desc_valid=0, all descriptor outputs 0, irq=0.
  - Reset mid-operation discards queued descriptors.

Decomposition:
- Package gemm_cfg_pkg holds:
  - desc_t packed struct: five 32-bit addr/stride fields, 3xDIM_W dims, store, overwrite.
  - Register offset localparams.
  - Status bit index constants.
- Sub-module desc_fifo: DEPTH x desc_t synchronous FIFO with push, pop, full, empty and count, active-low synchronous reset.

Test Plan:
- Reset, then read status -> 0x0000_0001 (empty=1); desc_valid=0; irq=0.
- Write A=0x1000, B=0x2000, C=0x3000, strides 64/128, control=0x3, dims m=4,k=8,n=16 (0x4104), then ring doorbell -> next cycle desc_valid=1, head fields match, store=1, overwrite=1, msize=4, ksize=8, nsize=16; status count=1.
- Ring doorbell DEPTH+1 times with desc_ready=0 -> full=1, overflow=1, count=DEPTH. Write status with 0x4 -> overflow=0, queue still full.
- With queue full, ring doorbell while desc_ready=1 -> count stays DEPTH, overflow stays 0, and the new descriptor is at the tail (verified by draining in order).
- irq_en=1; pulse tile_done 3 times -> done_cnt=3, irq=1. Write status 0x8 -> irq=0. Pulse tile_done in the same cycle as the W1C -> pending stays 1.
- Pop with desc_ready and push with 2 queued -> pointers wrap past DEPTH-1 correctly. Assert rst low mid-stream -> desc_valid=0 and count=0 next cycle.
